// File: rtl/ob_sorted_table.sv
// ob_sorted_table: one side (bid or ask) of a price-time sorted order book.
// Entries stay contiguous in slots 0..count-1, best entry in slot 0. Accepts
// one command per cycle (insert, pop, cancel-by-uid, reduce-top) and returns a
// registered response held stable until the consumer takes it.

package ob_pkg;

    typedef struct packed {
        logic [31:0] uid;
        logic [15:0] quantity;
        logic [19:0] price;     // packed BCD, compared as a raw unsigned value
    } table_t;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_POP    = 2'b01,
        OP_CANCEL = 2'b10,
        OP_REDUCE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_OKAY        = 3'b000,
        ST_FULL        = 3'b001,
        ST_CANCEL_HIT  = 3'b010,
        ST_CANCEL_MISS = 3'b011,
        ST_BAD         = 3'b100,
        ST_BAD_POP     = 3'b101,
        ST_EVICT       = 3'b110
    } status_e;

endpackage

module ob_sorted_table
    import ob_pkg::*;
#(
    parameter int N      = 4,
    parameter bit IS_BID = 1'b1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [1:0]               cmd_op,
    input  table_t                   cmd_entry,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output logic [2:0]               rsp_status,
    output table_t                   rsp_entry,
    output table_t                   head,
    output logic                     head_vld,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     full
);

    localparam int CW = $clog2(N + 1);

    // Empty-slot filler: the worst possible price for this side, so an empty
    // slot never outranks a real entry when the table is inspected directly.
    localparam table_t INIT = '{
        uid:      32'd0,
        quantity: 16'd0,
        price:    (IS_BID ? 20'h00000 : 20'h99999)
    };

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    table_t          r_slot [N];
    logic [CW-1:0]   r_count;
    logic            r_rsp_vld;
    status_e         r_rsp_status;
    table_t          r_rsp_entry;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_empty;
    logic            w_full;
    logic [CW-1:0]   w_ins_pos;      // N means "behind every slot"
    logic            w_hit;
    logic [CW-1:0]   w_hit_pos;
    table_t          w_hit_entry;
    logic [CW-1:0]   w_rm_pos;
    table_t          w_ins_tab [N];
    table_t          w_rm_tab  [N];
    table_t          w_nxt_slot [N];
    logic [CW-1:0]   w_nxt_count;
    status_e         w_nxt_status;
    table_t          w_nxt_entry;

    // True when price a ranks strictly ahead of price b on this side.
    function automatic logic is_better(input logic [19:0] a, input logic [19:0] b);
        if (IS_BID) begin
            return a > b;
        end
        return a < b;
    endfunction

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(N));
    assign cmd_rdy  = !r_rsp_vld || rsp_rdy;
    assign w_accept = cmd_vld && cmd_rdy;

    // Sorted insert position: first slot that is empty or strictly worse than
    // the new price, so a new entry lands behind every equal price (time priority).
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths
        // that skip an assignment would infer a latch.
        w_ins_pos = CW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (CW'(i) >= r_count || is_better(cmd_entry.price, r_slot[i].price)) begin
                w_ins_pos = CW'(i);
            end
        end
    end

    // Lowest valid slot whose uid matches the cancel request.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_pos   = '0;
        w_hit_entry = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (CW'(i) < r_count && r_slot[i].uid == cmd_entry.uid) begin
                w_hit       = 1'b1;
                w_hit_pos   = CW'(i);
                w_hit_entry = r_slot[i];
            end
        end
    end

    // Table image after inserting cmd_entry at w_ins_pos; the old last slot
    // falls off the end (an empty filler when not full, the victim when full).
    always_comb begin
        w_ins_tab[0] = (w_ins_pos == '0) ? cmd_entry : r_slot[0];
        for (int i = 1; i < N; i++) begin
            if (CW'(i) < w_ins_pos) begin
                w_ins_tab[i] = r_slot[i];
            end else if (CW'(i) == w_ins_pos) begin
                w_ins_tab[i] = cmd_entry;
            end else begin
                w_ins_tab[i] = r_slot[i-1];
            end
        end
    end

    // Table image after removing slot w_rm_pos; later entries move up one and
    // the freed tail slot returns to the filler value.
    always_comb begin
        w_rm_pos = (op_e'(cmd_op) == OP_CANCEL) ? w_hit_pos : '0;
        for (int i = 0; i < N - 1; i++) begin
            w_rm_tab[i] = (CW'(i) < w_rm_pos) ? r_slot[i] : r_slot[i+1];
        end
        w_rm_tab[N-1] = INIT;
    end

    // Command decode: next table, count and response for an accepted command.
    always_comb begin
        w_nxt_slot   = r_slot;
        w_nxt_count  = r_count;
        w_nxt_status = ST_OKAY;
        w_nxt_entry  = '0;
        case (op_e'(cmd_op))
            OP_INSERT: begin
                w_nxt_entry = cmd_entry;
                if (cmd_entry.quantity == '0) begin
                    w_nxt_status = ST_BAD;
                end else if (!w_full) begin
                    w_nxt_slot  = w_ins_tab;
                    w_nxt_count = r_count + CW'(1);
                end else if (w_ins_pos < CW'(N)) begin
                    w_nxt_slot   = w_ins_tab;
                    w_nxt_status = ST_EVICT;
                    w_nxt_entry  = r_slot[N-1];
                end else begin
                    w_nxt_status = ST_FULL;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_nxt_status = ST_BAD_POP;
                end else begin
                    w_nxt_slot  = w_rm_tab;
                    w_nxt_count = r_count - CW'(1);
                    w_nxt_entry = r_slot[0];
                end
            end
            OP_CANCEL: begin
                if (w_hit) begin
                    w_nxt_slot   = w_rm_tab;
                    w_nxt_count  = r_count - CW'(1);
                    w_nxt_status = ST_CANCEL_HIT;
                    w_nxt_entry  = w_hit_entry;
                end else begin
                    w_nxt_status = ST_CANCEL_MISS;
                end
            end
            OP_REDUCE: begin
                if (w_empty) begin
                    w_nxt_status = ST_BAD_POP;
                end else if (cmd_entry.quantity == '0) begin
                    w_nxt_status = ST_BAD;
                    w_nxt_entry  = cmd_entry;
                end else if (cmd_entry.quantity < r_slot[0].quantity) begin
                    // Partial fill: the compare above guarantees no underflow.
                    w_nxt_slot[0].quantity = r_slot[0].quantity - cmd_entry.quantity;
                    w_nxt_entry            = r_slot[0];
                    w_nxt_entry.quantity   = cmd_entry.quantity;
                end else begin
                    // Fill consumes the whole head: behaves like a pop.
                    w_nxt_slot  = w_rm_tab;
                    w_nxt_count = r_count - CW'(1);
                    w_nxt_entry = r_slot[0];
                end
            end
            default: begin
                w_nxt_status = ST_BAD;
            end
        endcase
    end

    // Table, count and response registers: update together on an accepted command.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: the slots are flops, not a RAM, and must come out of reset
            // holding the filler value, so each one is reset explicitly.
            for (int i = 0; i < N; i++) begin
                r_slot[i] <= INIT;
            end
            r_count      <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_status <= ST_OKAY;
            r_rsp_entry  <= '0;
        end else if (w_accept) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_slot       <= w_nxt_slot;
            r_count      <= w_nxt_count;
            r_rsp_vld    <= 1'b1;
            r_rsp_status <= w_nxt_status;
            r_rsp_entry  <= w_nxt_entry;
        end else if (rsp_rdy) begin
            r_rsp_vld    <= 1'b0;
        end
    end

    assign rsp_vld    = r_rsp_vld;
    assign rsp_status = r_rsp_status;
    assign rsp_entry  = r_rsp_entry;
    assign head       = r_slot[0];
    assign head_vld   = !w_empty;
    assign count      = r_count;
    assign full       = w_full;

endmodule

// File: tb/tb_ob_sorted_table.sv
// Self-checking bench for ob_sorted_table: a bid instance (N=4) and an ask
// instance (N=2) share the command inputs; directed vector tables plus
// hand-written backpressure and mid-operation reset sequences.

module tb_ob_sorted_table;
    import ob_pkg::*;

    localparam int NB = 4;
    localparam int NA = 2;

    logic        clk;
    logic        arst_n;
    logic        cmd_vld;
    logic [1:0]  cmd_op;
    table_t      cmd_entry;
    logic        rsp_rdy;

    logic        b_cmd_rdy, b_rsp_vld, b_head_vld, b_full;
    logic [2:0]  b_rsp_status;
    table_t      b_rsp_entry, b_head;
    logic [2:0]  b_count;

    logic        a_cmd_rdy, a_rsp_vld, a_head_vld, a_full;
    logic [2:0]  a_rsp_status;
    table_t      a_rsp_entry, a_head;
    logic [1:0]  a_count;

    int n_checks = 0;
    int n_fail   = 0;

    ob_sorted_table #(.N(NB), .IS_BID(1'b1)) dut_bid (
        .clk(clk), .arst_n(arst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_op(cmd_op), .cmd_entry(cmd_entry),
        .rsp_vld(b_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_status(b_rsp_status), .rsp_entry(b_rsp_entry),
        .head(b_head), .head_vld(b_head_vld), .count(b_count), .full(b_full)
    );

    ob_sorted_table #(.N(NA), .IS_BID(1'b0)) dut_ask (
        .clk(clk), .arst_n(arst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_op(cmd_op), .cmd_entry(cmd_entry),
        .rsp_vld(a_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_status(a_rsp_status), .rsp_entry(a_rsp_entry),
        .head(a_head), .head_vld(a_head_vld), .count(a_count), .full(a_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        table_t     entry;
        logic [2:0] exp_status;
        table_t     exp_rsp;
        bit         chk_rsp;
        int         exp_count;
        table_t     exp_head;
    } vec_t;

    vec_t bid_vecs [22];
    vec_t ask_vecs [6];

    localparam table_t BID_INIT = '{uid: 32'd0, quantity: 16'd0, price: 20'h00000};
    localparam table_t ASK_INIT = '{uid: 32'd0, quantity: 16'd0, price: 20'h99999};

    function automatic table_t mk(input int unsigned u, input int unsigned q, input logic [19:0] p);
        table_t t;
        t.uid      = u;
        t.quantity = q[15:0];
        t.price    = p;
        return t;
    endfunction

    function automatic vec_t v(input logic [1:0] op, input table_t e, input logic [2:0] st,
                               input table_t r, input bit cr, input int c, input table_t h);
        vec_t x;
        x.op = op; x.entry = e; x.exp_status = st; x.exp_rsp = r;
        x.chk_rsp = cr; x.exp_count = c; x.exp_head = h;
        return x;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one command with rsp_rdy=1; outputs are valid on return (negedge after accept).
    task automatic issue(input logic [1:0] op, input table_t e);
        int budget;
        @(negedge clk);
        cmd_vld   = 1'b1;
        cmd_op    = op;
        cmd_entry = e;
        rsp_rdy   = 1'b1;
        budget    = 0;
        while (!b_cmd_rdy && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!b_cmd_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_rdy wait: got 0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic run_vec(input bit is_bid, input vec_t x, input int idx);
        logic        vld, hv, fl;
        logic [2:0]  st;
        table_t      re, hd;
        int          cnt, n;
        issue(x.op, x.entry);
        if (is_bid) begin
            vld = b_rsp_vld; st = b_rsp_status; re = b_rsp_entry; hd = b_head;
            hv = b_head_vld; fl = b_full; cnt = int'(b_count); n = NB;
        end else begin
            vld = a_rsp_vld; st = a_rsp_status; re = a_rsp_entry; hd = a_head;
            hv = a_head_vld; fl = a_full; cnt = int'(a_count); n = NA;
        end
        check($sformatf("%s[%0d] rsp_vld", is_bid ? "bid" : "ask", idx), 68'(vld), 68'(1));
        check($sformatf("%s[%0d] status", is_bid ? "bid" : "ask", idx), 68'(st), 68'(x.exp_status));
        if (x.chk_rsp)
            check($sformatf("%s[%0d] rsp_entry", is_bid ? "bid" : "ask", idx), re, x.exp_rsp);
        check($sformatf("%s[%0d] count", is_bid ? "bid" : "ask", idx), 68'(cnt), 68'(x.exp_count));
        check($sformatf("%s[%0d] head", is_bid ? "bid" : "ask", idx), hd, x.exp_head);
        check($sformatf("%s[%0d] head_vld", is_bid ? "bid" : "ask", idx), 68'(hv), 68'(x.exp_count != 0));
        check($sformatf("%s[%0d] full", is_bid ? "bid" : "ask", idx), 68'(fl), 68'(x.exp_count == n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_vld = 1'b0;
        arst_n  = 1'b0;
        @(negedge clk);
        arst_n  = 1'b1;
    endtask

    initial begin
        // Bid side, N=4. Prices in BCD: 0x01000 = 10.00 etc.
        bid_vecs[0]  = v(OP_INSERT, mk(1,5,20'h01000), ST_OKAY,        mk(1,5,20'h01000), 1, 1, mk(1,5,20'h01000));
        bid_vecs[1]  = v(OP_INSERT, mk(2,3,20'h01200), ST_OKAY,        mk(2,3,20'h01200), 1, 2, mk(2,3,20'h01200));
        bid_vecs[2]  = v(OP_INSERT, mk(3,7,20'h01000), ST_OKAY,        mk(3,7,20'h01000), 1, 3, mk(2,3,20'h01200));
        bid_vecs[3]  = v(OP_INSERT, mk(4,0,20'h01500), ST_BAD,         mk(4,0,20'h01500), 1, 3, mk(2,3,20'h01200));
        bid_vecs[4]  = v(OP_CANCEL, mk(1,0,20'h0),     ST_CANCEL_HIT,  mk(1,5,20'h01000), 1, 2, mk(2,3,20'h01200));
        bid_vecs[5]  = v(OP_CANCEL, mk(77,0,20'h0),    ST_CANCEL_MISS, '0,                1, 2, mk(2,3,20'h01200));
        bid_vecs[6]  = v(OP_POP,    mk(0,0,20'h0),     ST_OKAY,        mk(2,3,20'h01200), 1, 1, mk(3,7,20'h01000));
        bid_vecs[7]  = v(OP_INSERT, mk(4,6,20'h01000), ST_OKAY,        mk(4,6,20'h01000), 1, 2, mk(3,7,20'h01000));
        bid_vecs[8]  = v(OP_INSERT, mk(5,2,20'h01000), ST_OKAY,        mk(5,2,20'h01000), 1, 3, mk(3,7,20'h01000));
        bid_vecs[9]  = v(OP_INSERT, mk(6,8,20'h01000), ST_OKAY,        mk(6,8,20'h01000), 1, 4, mk(3,7,20'h01000));
        bid_vecs[10] = v(OP_INSERT, mk(7,1,20'h00900), ST_FULL,        mk(7,1,20'h00900), 1, 4, mk(3,7,20'h01000));
        bid_vecs[11] = v(OP_INSERT, mk(8,1,20'h01000), ST_FULL,        mk(8,1,20'h01000), 1, 4, mk(3,7,20'h01000));
        bid_vecs[12] = v(OP_INSERT, mk(9,5,20'h01100), ST_EVICT,       mk(6,8,20'h01000), 1, 4, mk(9,5,20'h01100));
        bid_vecs[13] = v(OP_CANCEL, mk(4,0,20'h0),     ST_CANCEL_HIT,  mk(4,6,20'h01000), 1, 3, mk(9,5,20'h01100));
        bid_vecs[14] = v(OP_REDUCE, mk(0,2,20'h0),     ST_OKAY,        mk(9,2,20'h01100), 1, 3, mk(9,3,20'h01100));
        bid_vecs[15] = v(OP_REDUCE, mk(0,9,20'h0),     ST_OKAY,        mk(9,3,20'h01100), 1, 2, mk(3,7,20'h01000));
        bid_vecs[16] = v(OP_REDUCE, mk(0,0,20'h0),     ST_BAD,         '0,                0, 2, mk(3,7,20'h01000));
        bid_vecs[17] = v(OP_REDUCE, mk(0,7,20'h0),     ST_OKAY,        mk(3,7,20'h01000), 1, 1, mk(5,2,20'h01000));
        bid_vecs[18] = v(OP_POP,    mk(0,0,20'h0),     ST_OKAY,        mk(5,2,20'h01000), 1, 0, BID_INIT);
        bid_vecs[19] = v(OP_POP,    mk(0,0,20'h0),     ST_BAD_POP,     '0,                1, 0, BID_INIT);
        bid_vecs[20] = v(OP_REDUCE, mk(0,1,20'h0),     ST_BAD_POP,     '0,                0, 0, BID_INIT);
        bid_vecs[21] = v(OP_CANCEL, mk(5,0,20'h0),     ST_CANCEL_MISS, '0,                1, 0, BID_INIT);

        // Ask side, N=2: ascending price.
        ask_vecs[0] = v(OP_INSERT, mk(1,1,20'h01000), ST_OKAY,  mk(1,1,20'h01000), 1, 1, mk(1,1,20'h01000));
        ask_vecs[1] = v(OP_INSERT, mk(2,1,20'h00900), ST_OKAY,  mk(2,1,20'h00900), 1, 2, mk(2,1,20'h00900));
        ask_vecs[2] = v(OP_INSERT, mk(3,1,20'h01100), ST_FULL,  mk(3,1,20'h01100), 1, 2, mk(2,1,20'h00900));
        ask_vecs[3] = v(OP_INSERT, mk(4,1,20'h00800), ST_EVICT, mk(1,1,20'h01000), 1, 2, mk(4,1,20'h00800));
        ask_vecs[4] = v(OP_POP,    mk(0,0,20'h0),     ST_OKAY,  mk(4,1,20'h00800), 1, 1, mk(2,1,20'h00900));
        ask_vecs[5] = v(OP_POP,    mk(0,0,20'h0),     ST_OKAY,  mk(2,1,20'h00900), 1, 0, ASK_INIT);

        cmd_vld   = 1'b0;
        cmd_op    = 2'b00;
        cmd_entry = '0;
        rsp_rdy   = 1'b1;
        arst_n    = 1'b0;
        #12;

        // Reset state of both sides.
        check("reset bid count",    68'(b_count), 68'(0));
        check("reset bid head_vld", 68'(b_head_vld), 68'(0));
        check("reset bid rsp_vld",  68'(b_rsp_vld), 68'(0));
        check("reset bid status",   68'(b_rsp_status), 68'(0));
        check("reset bid rsp",      b_rsp_entry, 68'(0));
        check("reset bid head",     b_head, BID_INIT);
        check("reset ask head",     a_head, ASK_INIT);
        check("reset ask count",    68'(a_count), 68'(0));
        arst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(1'b0, ask_vecs[i], i);
        do_reset();
        for (int i = 0; i < 22; i++) run_vec(1'b1, bid_vecs[i], i);

        // Backpressure: response held, commands blocked, table frozen.
        @(negedge clk);
        cmd_vld   = 1'b1;
        cmd_op    = OP_INSERT;
        cmd_entry = mk(20,5,20'h00500);
        rsp_rdy   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_op    = OP_POP;
        cmd_entry = '0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d cmd_rdy", k),  68'(b_cmd_rdy), 68'(0));
            check($sformatf("stall%0d rsp_vld", k),  68'(b_rsp_vld), 68'(1));
            check($sformatf("stall%0d status", k),   68'(b_rsp_status), 68'(ST_OKAY));
            check($sformatf("stall%0d rsp", k),      b_rsp_entry, mk(20,5,20'h00500));
            check($sformatf("stall%0d count", k),    68'(b_count), 68'(1));
            check($sformatf("stall%0d head", k),     b_head, mk(20,5,20'h00500));
            @(posedge clk);
            @(negedge clk);
        end
        // Release: old response consumed and the waiting POP accepted on the same edge.
        rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        check("release rsp_vld", 68'(b_rsp_vld), 68'(1));
        check("release status",  68'(b_rsp_status), 68'(ST_OKAY));
        check("release rsp",     b_rsp_entry, mk(20,5,20'h00500));
        check("release count",   68'(b_count), 68'(0));
        @(posedge clk);
        @(negedge clk);
        check("drain rsp_vld",   68'(b_rsp_vld), 68'(0));

        issue(OP_POP, '0);
        check("empty pop status", 68'(b_rsp_status), 68'(ST_BAD_POP));
        check("empty pop rsp",    b_rsp_entry, 68'(0));

        // Reset while a response is pending.
        @(negedge clk);
        cmd_vld   = 1'b1;
        cmd_op    = OP_INSERT;
        cmd_entry = mk(30,4,20'h02000);
        rsp_rdy   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        check("pre-reset rsp_vld", 68'(b_rsp_vld), 68'(1));
        check("pre-reset count",   68'(b_count), 68'(1));
        arst_n = 1'b0;
        #1;
        check("mid reset rsp_vld", 68'(b_rsp_vld), 68'(0));
        check("mid reset count",   68'(b_count), 68'(0));
        check("mid reset head",    b_head, BID_INIT);
        check("mid reset status",  68'(b_rsp_status), 68'(0));
        @(negedge clk);
        arst_n  = 1'b1;
        rsp_rdy = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
